// File: rtl/bpsk_pkg.sv
// Shared types and sine-table generation for the BPSK transmitter.
// Differential encoding is selected in the modulator by the BPSK_DIFF_EN macro.
package bpsk_pkg;

   localparam int unsigned DataWidthDef     = 12;
   localparam int unsigned SineTableSizeDef = 32;
   localparam int unsigned WavelengthDef    = 2 * SineTableSizeDef;
   localparam int unsigned PhaseWidth       = $clog2(WavelengthDef);

   typedef logic signed [DataWidthDef-1:0] sample_t;

   typedef enum logic [0:0] {
      StIdle,
      StSend
   } state_e;

   // Positive half-wave entry i: round((2^(dw-1)-1) * sin(pi*i/size)); never negative.
   function automatic int sine_entry(input int unsigned i, input int unsigned table_size,
                                     input int unsigned data_width);
      real amp;
      real ang;
      amp = real'((1 << (data_width - 1)) - 1);
      ang = 3.14159265358979323846 * real'(i) / real'(table_size);
      return $rtoi(amp * $sin(ang) + 0.5);
   endfunction

endpackage

// File: rtl/sine_lut.sv
// Registered sine ROM: half-wave table, second half produced by negation.
// Output is forced to zero when not enabled so the idle line stays quiet.
module sine_lut
   import bpsk_pkg::*;
#(
   parameter int unsigned DATA_WIDTH      = 12,
   parameter int unsigned SINE_TABLE_SIZE = 32
) (
   input  logic                                   clk_i,
   input  logic                                   rst_ni,
   input  logic                                   en_i,
   input  logic [$clog2(2*SINE_TABLE_SIZE)-1:0]   index_i,
   output logic signed [DATA_WIDTH-1:0]           value_o
);

   localparam int unsigned AddrW = $clog2(SINE_TABLE_SIZE);

   logic signed [DATA_WIDTH-1:0] half_tab [SINE_TABLE_SIZE];
   logic signed [DATA_WIDTH-1:0] value_q;
   logic [AddrW-1:0]             addr;
   logic                         neg_half;

   for (genvar g = 0; g < SINE_TABLE_SIZE; g++) begin : g_tab
      assign half_tab[g] = DATA_WIDTH'(sine_entry(g, SINE_TABLE_SIZE, DATA_WIDTH));
   end

   assign addr     = index_i[AddrW-1:0];
   assign neg_half = index_i[AddrW];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         value_q <= '0;
      end else if (!en_i) begin
         value_q <= '0;
      end else begin
         value_q <= neg_half ? -half_tab[addr] : half_tab[addr];
      end
   end

   assign value_o = value_q;

endmodule

// File: rtl/bpsk_modulator.sv
// BPSK transmitter: serialises packets MSB-first onto a table-driven sine carrier.
// Define BPSK_DIFF_EN for differential encoding (a data 1 flips the carrier phase).
module bpsk_modulator
   import bpsk_pkg::*;
#(
   parameter int unsigned DATA_WIDTH      = 12,
   parameter int unsigned SINE_TABLE_SIZE = 32,
   parameter int unsigned WAVELENGTH      = 2 * SINE_TABLE_SIZE,
   parameter int unsigned CYCLES_PER_BIT  = 1,
   parameter int unsigned PACKET_SIZE     = 16
) (
   input  logic                         clock,
   input  logic                         reset_n,
   input  logic [PACKET_SIZE-1:0]       pkt_data,
   input  logic                         pkt_valid,
   output logic                         pkt_ready,
   output logic signed [DATA_WIDTH-1:0] sample,
   output logic                         sample_valid,
   output logic                         bit_out,
   output logic                         sym_start,
   output logic                         busy
);

   localparam int unsigned PhaseW     = $clog2(WAVELENGTH);
   localparam int unsigned SampPerBit = CYCLES_PER_BIT * WAVELENGTH;
   localparam int unsigned CntW       = $clog2(SampPerBit);
   localparam int unsigned BitW       = (PACKET_SIZE > 1) ? $clog2(PACKET_SIZE) : 1;

   if (WAVELENGTH != 2 * SINE_TABLE_SIZE) begin : g_bad_wavelength
      $error("WAVELENGTH must equal 2*SINE_TABLE_SIZE");
   end

   state_e                 state_q, state_d;
   logic [PhaseW-1:0]      phase_q, phase_d;
   logic [CntW-1:0]        samp_cnt_q, samp_cnt_d;
   logic [BitW-1:0]        bit_cnt_q, bit_cnt_d;
   logic [PACKET_SIZE-1:0] shreg_q, shreg_d;
`ifdef BPSK_DIFF_EN
   logic                   t_prev_q, t_prev_d;
`endif
   logic                   ready_en_q;
   logic                   sample_valid_q, bit_out_q, sym_start_q;

   logic                   symbol;
   logic                   last_bit_sample;
   logic                   last_sample;
   logic                   accept;
   logic [PhaseW-1:0]      lut_index;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= StIdle;
         phase_q        <= '0;
         samp_cnt_q     <= '0;
         bit_cnt_q      <= '0;
         shreg_q        <= '0;
`ifdef BPSK_DIFF_EN
         t_prev_q       <= 1'b1;
`endif
         ready_en_q     <= 1'b0;
         sample_valid_q <= 1'b0;
         bit_out_q      <= 1'b0;
         sym_start_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         phase_q        <= phase_d;
         samp_cnt_q     <= samp_cnt_d;
         bit_cnt_q      <= bit_cnt_d;
         shreg_q        <= shreg_d;
`ifdef BPSK_DIFF_EN
         t_prev_q       <= t_prev_d;
`endif
         ready_en_q     <= 1'b1;
         sample_valid_q <= busy;
         bit_out_q      <= busy & symbol;
         sym_start_q    <= busy & (samp_cnt_q == '0);
      end
   end

   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      samp_cnt_d = samp_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shreg_d    = shreg_q;
`ifdef BPSK_DIFF_EN
      t_prev_d   = t_prev_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               state_d    = StSend;
               phase_d    = '0;
               samp_cnt_d = '0;
               bit_cnt_d  = '0;
               shreg_d    = pkt_data;
`ifdef BPSK_DIFF_EN
               t_prev_d   = 1'b1;
`endif
            end
         end
         StSend: begin
            phase_d = phase_q + 1'b1;
            if (last_bit_sample) begin
               samp_cnt_d = '0;
`ifdef BPSK_DIFF_EN
               t_prev_d   = symbol;
`endif
               if (last_sample) begin
                  bit_cnt_d = '0;
                  // Back-to-back load keeps the phase running for a gapless carrier.
                  if (accept) begin
                     shreg_d = pkt_data;
                  end else begin
                     state_d = StIdle;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
                  shreg_d   = shreg_q << 1;
               end
            end else begin
               samp_cnt_d = samp_cnt_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      busy            = (state_q == StSend);
      last_bit_sample = busy && (samp_cnt_q == CntW'(SampPerBit - 1));
      last_sample     = last_bit_sample && (bit_cnt_q == BitW'(PACKET_SIZE - 1));
      pkt_ready       = ready_en_q & ((state_q == StIdle) | last_sample);
      accept          = pkt_valid & pkt_ready;
`ifdef BPSK_DIFF_EN
      symbol          = t_prev_q ^ shreg_q[PACKET_SIZE-1];
`else
      symbol          = shreg_q[PACKET_SIZE-1];
`endif
      lut_index       = phase_q + (symbol ? PhaseW'(0) : PhaseW'(WAVELENGTH / 2));
   end

   sine_lut #(
      .DATA_WIDTH      (DATA_WIDTH),
      .SINE_TABLE_SIZE (SINE_TABLE_SIZE)
   ) u_sine_lut (
      .clk_i   (clock),
      .rst_ni  (reset_n),
      .en_i    (busy),
      .index_i (lut_index),
      .value_o (sample)
   );

   assign sample_valid = sample_valid_q;
   assign bit_out      = bit_out_q;
   assign sym_start    = sym_start_q;

endmodule

// File: tb/tb_bpsk_modulator.sv
// Scoreboard bench for bpsk_modulator: stimulus pushes expected samples, a monitor pops them.
// Builds for either encoding; expectations follow BPSK_DIFF_EN.
module tb_bpsk_modulator;

`ifdef BPSK_DIFF_EN
   localparam bit Diff = 1'b1;
`else
   localparam bit Diff = 1'b0;
`endif
   localparam real PI = 3.14159265358979323846;

   logic               clock = 1'b0;
   logic               reset_n = 1'b0;
   logic [15:0]        pkt_data, pkt_data3;
   logic               pkt_valid, pkt_valid3;
   logic               pkt_ready, pkt_ready3;
   logic signed [11:0] sample, sample3;
   logic               sample_valid, sample_valid3;
   logic               bit_out, bit_out3;
   logic               sym_start, sym_start3;
   logic               busy, busy3;

   always #5 clock = ~clock;

   bpsk_modulator dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .pkt_data     (pkt_data),
      .pkt_valid    (pkt_valid),
      .pkt_ready    (pkt_ready),
      .sample       (sample),
      .sample_valid (sample_valid),
      .bit_out      (bit_out),
      .sym_start    (sym_start),
      .busy         (busy)
   );

   bpsk_modulator #(.CYCLES_PER_BIT(3)) dut3 (
      .clock        (clock),
      .reset_n      (reset_n),
      .pkt_data     (pkt_data3),
      .pkt_valid    (pkt_valid3),
      .pkt_ready    (pkt_ready3),
      .sample       (sample3),
      .sample_valid (sample_valid3),
      .bit_out      (bit_out3),
      .sym_start    (sym_start3),
      .busy         (busy3)
   );

   typedef struct {
      int   s;
      logic b;
      logic st;
   } exp_t;

   exp_t        sb[$];
   int          tests = 0;
   int          fails = 0;
   int          valid_total = 0;
   int          run_len = 0;
   int          last_run = 0;
   int          sample_idx = 0;
   logic [15:0] bits_seen = '0;
   logic        model_t = 1'b1;
   int          cyc = 0;
   int          last3 = 0;
   int          pulses3 = 0;
   int          valid3 = 0;

   task automatic check(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   function automatic int ref_sample(input int idx);
      int i;
      int r;
      i = idx % 32;
      r = $rtoi(2047.0 * $sin(PI * real'(i) / 32.0) + 0.5);
      return (idx >= 32) ? -r : r;
   endfunction

   task automatic push_packet(input logic [15:0] d, input bit b2b);
      logic sym;
      exp_t e;
      if (!b2b) model_t = 1'b1;
      for (int k = 0; k < 16; k++) begin
         sym     = Diff ? (model_t ^ d[15-k]) : d[15-k];
         model_t = sym;
         for (int j = 0; j < 64; j++) begin
            e.s  = ref_sample(sym ? j : (j + 32) % 64);
            e.b  = sym;
            e.st = (j == 0);
            sb.push_back(e);
         end
      end
   endtask

   task automatic send(input logic [15:0] d, input bit b2b);
      int n = 0;
      @(negedge clock);
      pkt_data  = d;
      pkt_valid = 1'b1;
      while (!pkt_ready && n < 5000) begin
         @(negedge clock);
         n++;
      end
      check("handshake_ready", int'(pkt_ready), 1);
      if (pkt_ready) push_packet(d, b2b);
      @(posedge clock);
      #1 pkt_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 10000) begin
         @(negedge clock);
         n++;
      end
      check("idle_timeout_busy", int'(busy), 0);
      repeat (3) @(negedge clock);
   endtask

   always @(posedge clock) cyc++;

   always @(negedge clock) begin
      exp_t e;
      if (sample_valid) begin
         valid_total++;
         run_len++;
         if (sym_start) bits_seen = {bits_seen[14:0], bit_out};
         if (sb.size() == 0) begin
            check("unexpected_sample", 1, 0);
         end else begin
            e = sb.pop_front();
            tests++;
            if (int'(sample) != e.s || bit_out != e.b || sym_start != e.st) begin
               fails++;
               $display("FAIL sample[%0d]: got s=%0d b=%0b st=%0b, required s=%0d b=%0b st=%0b",
                        sample_idx, sample, bit_out, sym_start, e.s, e.b, e.st);
            end
            sample_idx++;
         end
      end else begin
         if (run_len != 0) last_run = run_len;
         run_len = 0;
         check("idle_outputs_zero", int'({sample, bit_out, sym_start} != '0), 0);
      end
   end

   always @(negedge clock) begin
      if (sample_valid3) valid3++;
      if (sym_start3) begin
         if (pulses3 > 0) check("cpb3_symbol_spacing", cyc - last3, 192);
         last3 = cyc;
         pulses3++;
      end
   end

   initial begin
      int v0;
      int n;
      pkt_data   = '0;
      pkt_valid  = 1'b0;
      pkt_data3  = '0;
      pkt_valid3 = 1'b0;

      // Reset behaviour and quiet idle line.
      #12;
      check("reset_pkt_ready", int'(pkt_ready), 0);
      check("reset_sample_valid", int'(sample_valid), 0);
      check("reset_busy", int'(busy), 0);
      @(negedge clock) reset_n = 1'b1;
      @(posedge clock);
      @(negedge clock);
      check("post_reset_ready", int'(pkt_ready), 1);
      repeat (20) @(negedge clock);
      check("idle_ready", int'(pkt_ready), 1);
      check("idle_busy", int'(busy), 0);
      check("idle_sample_valid", int'(sample_valid), 0);

      // Single packet 16'hCAFE: latency, peak values, length, symbol sequence.
      bits_seen = '0;
      v0 = valid_total;
      send(16'hCAFE, 1'b0);
      @(negedge clock);
      check("latency_c1_valid", int'(sample_valid), 0);
      check("latency_c1_busy", int'(busy), 1);
      @(negedge clock);
      check("latency_c2_valid", int'(sample_valid), 1);
      check("latency_c2_sym_start", int'(sym_start), 1);
      repeat (16) @(negedge clock);
      check("bit0_idx16", int'(sample), Diff ? -2047 : 2047);
      repeat (128) @(negedge clock);
      check("bit2_idx16", int'(sample), Diff ? 2047 : -2047);
      wait_idle();
      check("cafe_valid_cycles", valid_total - v0, 1024);
      check("cafe_bit_seq", int'(bits_seen), Diff ? 32'h7354 : 32'hCAFE);

      // Back-to-back packets give one continuous 2048-sample stream.
      send(16'hCAFE, 1'b0);
      send(16'h0001, 1'b1);
      wait_idle();
      check("b2b_run_length", last_run, 2048);
      check("b2b_sb_drained", sb.size(), 0);

      // Three carrier cycles per bit on the second instance.
      @(negedge clock);
      pkt_data3  = 16'hCAFE;
      pkt_valid3 = 1'b1;
      @(posedge clock);
      #1 pkt_valid3 = 1'b0;
      n = 0;
      while (busy3 && n < 10000) begin
         @(negedge clock);
         n++;
      end
      repeat (3) @(negedge clock);
      check("cpb3_sym_pulses", pulses3, 16);
      check("cpb3_valid_cycles", valid3, 3072);

      // Reset mid-packet drops it; the next packet starts from phase 0.
      send(16'h1234, 1'b0);
      repeat (299) @(posedge clock);
      #2 reset_n = 1'b0;
      #1;
      check("midreset_sample", int'(sample), 0);
      check("midreset_valid", int'(sample_valid), 0);
      check("midreset_busy", int'(busy), 0);
      check("midreset_ready", int'(pkt_ready), 0);
      sb.delete();
      @(negedge clock) reset_n = 1'b1;
      @(posedge clock);
      send(16'h8000, 1'b0);
      wait_idle();
      check("after_reset_sb_drained", sb.size(), 0);

      // All-ones packet: alternating symbols when differential.
      bits_seen = '0;
      send(16'hFFFF, 1'b0);
      wait_idle();
      check("ffff_bit_seq", int'(bits_seen), Diff ? 32'h5555 : 32'hFFFF);
      check("final_sb_drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/bpsk_modulator.md
# bpsk_modulator

- Parametrised BPSK transmitter.
- Accepts PACKET_SIZE-bit packets over a valid/ready handshake and serialises them MSB-first.
- Each bit modulates a table-driven sine carrier: bit 1 → 0°, bit 0 → 180° (SHIFT = WAVELENGTH/2).
- Emits one signed sample per clock. It is the successor to the fixed phase-counter / sine-generator / bit-sender chain, and feeds the receiver or DAC path.

## Interface
Parameters:
- DATA_WIDTH, 12: sample width, signed.
- SINE_TABLE_SIZE, 32: half-wave table entries.
- WAVELENGTH, 2*SINE_TABLE_SIZE: samples per carrier cycle. Must equal 2*SINE_TABLE_SIZE and be a power of two.
- CYCLES_PER_BIT, 1: carrier cycles per symbol, ≥1.
- PACKET_SIZE, 16: bits per packet.

Ports (one clock; reset is asynchronous and active-low):
- clock  in  1  system clock
- reset_n  in  1  async active-low reset
- pkt_data  in  PACKET_SIZE  packet, MSB sent first
- pkt_valid  in  1  packet offered
- pkt_ready  out  1  packet accepted when pkt_valid & pkt_ready
- sample  out  DATA_WIDTH  signed carrier sample
- sample_valid  out  1  sample is a modulated symbol sample
- bit_out  out  1  transmitted symbol bit, aligned with sample
- sym_start  out  1  pulses with first sample of each symbol
- busy  out  1  state is SEND

## Operation
- States: IDLE, SEND.
  - IDLE: pkt_ready=1. On handshake, capture pkt_data into shift register, clear phase, sample and bit counters, go to SEND.
  - SEND: phase increments mod WAVELENGTH each cycle.
    - Sample counter counts 0..CYCLES_PER_BIT*WAVELENGTH-1; on wrap, shift the next bit.
    - After the last sample of bit PACKET_SIZE-1, return to IDLE unless a new packet was accepted.
- Back-to-back: pkt_ready is also 1 during the final sample cycle of the final bit. A handshake there loads the new packet and stays in SEND. The phase counter is not cleared, so the carrier is continuous with no gap.
- pkt_valid held low in that cycle → IDLE next cycle.
- LUT index = (phase + (symbol ? 0 : WAVELENGTH/2)) mod WAVELENGTH.
- Table value i < SINE_TABLE_SIZE: round((2^(DATA_WIDTH-1)-1)*sin(pi*i/SINE_TABLE_SIZE)).
- Index ≥ SINE_TABLE_SIZE: two's-complement negation of entry (i - SINE_TABLE_SIZE). No saturation is needed since |value| ≤ 2^(DATA_WIDTH-1)-1.
- Reset values: pkt_ready=0 during reset, 1 on the first cycle after release. All other outputs 0; state IDLE.
- Reset asserted mid-packet: all state clears immediately and the packet is dropped; sample=0 asynchronously.
- pkt_data/pkt_valid are ignored in SEND except in the final-sample cycle.

## Timing
- Cycle 0: handshake.
- Cycle 1: SEND, phase 0 index registered into LUT.
- Cycle 2: first sample out, with sample_valid=1 and sym_start=1.
- Latency from handshake to first sample is 2 cycles.
- sample, sample_valid, bit_out and sym_start are all registered and mutually aligned, one cycle behind phase/state.
- A packet occupies exactly PACKET_SIZE*CYCLES_PER_BIT*WAVELENGTH consecutive sample_valid cycles.
- In IDLE (after the pipeline drains): sample=0 and sample_valid=0.

## Configuration
- BPSK_DIFF_EN defined: differential encoding.
  - Symbol t_k = t_(k-1) XOR d_k, so a data 1 flips phase.
  - t_(-1)=1, reloaded only on IDLE→SEND and carried across back-to-back packets.
  - bit_out reports t_k.
- BPSK_DIFF_EN undefined: t_k = d_k.

## Structure
- Package bpsk_pkg:
  - sample_t (signed DATA_WIDTH)
  - state enum {IDLE, SEND}
  - phase width localparam $clog2(WAVELENGTH)
  - sine table generation function
- Sub-module sine_lut: registered ROM, index in, sample_t out, 1-cycle latency, half-wave table plus negation.
- Counters and FSM live in bpsk_modulator.

## Test plan
- Reset release, pkt_valid=0 → sample=0, sample_valid=0, pkt_ready=1, busy=0 indefinitely.
- Defaults, pkt_data=16'hCAFE:
  - First sample 2 cycles after handshake.
  - Bit 0 sample index 16 = +2047.
  - Bit 2 (first '0') index 16 output = -2047.
  - sample_valid high exactly 1024 cycles.
  - bit_out sequence 1100101011111110.
- Two packets, 16'hCAFE then 16'h0001, with pkt_valid held → second handshake in the last sample cycle. Sample stream continuous for 2048 cycles; phase keeps incrementing across the boundary.
- CYCLES_PER_BIT=3 → each bit lasts 192 cycles; sym_start pulses every 192 cycles, 16 times.
- reset_n low at cycle 300 of a packet → outputs 0 immediately. After release, a new 16'h8000 transmits from phase 0.
- BPSK_DIFF_EN, pkt_data=16'hFFFF → bit_out alternates 0,1,0,1…; carrier phase flips each symbol.
